// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write scoreboard.
// Register index width follows NREG; the link register is the top register.
package rf_pkg;
    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int CNTW = 2;
    localparam int IDXW = $clog2(NREG);

    typedef logic [IDXW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;
    localparam reg_idx_t REG_LINK = reg_idx_t'(31);

    typedef struct packed {
        logic           we;
        reg_idx_t       addr;
        logic [DW-1:0]  data;
    } rf_wr_t;
endpackage

// File: rtl/rf_pend_cnt.sv
// Saturating pending-write counter for one architectural register.
// Updates at the clock edge; simultaneous inc and dec leave the count unchanged.
module rf_pend_cnt
    import rf_pkg::*;
#(
    parameter int CW = CNTW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic full
);

    logic [CW-1:0] cnt;

    assign nonzero = |cnt;
    assign full    = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A commit with nothing outstanding means WB reported a write ID never issued.
    error_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && !nonzero));

endmodule

// File: rtl/rf_write_scoreboard.sv
// RAW interlock and single write-port scheduler (WB over jal link) for the register file.
// Stall and link_ready are combinational; RF write is registered (1 cycle); link has a 1-entry buffer.
module rf_write_scoreboard
    import rf_pkg::*;
#(
    parameter int CW = CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic            iss_wr,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs,
    input  logic [4:0]      iss_rt,
    input  logic            iss_use_rs,
    input  logic            iss_use_rt,
    output logic            stall,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [DW-1:0]   wb_data,
    input  logic            link_valid,
    input  logic [DW-1:0]   link_data,
    output logic            link_ready,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:1] nz;
    logic [NREG-1:1] full;
    logic [NREG-1:1] inc_vec;
    logic [NREG-1:1] dec_vec;
    logic [NREG-1:0] nz_all;
    logic [NREG-1:0] full_all;

    logic            buf_full;
    logic [DW-1:0]   buf_data;
    logic            capture;
    logic            drain;
    rf_wr_t          sel;
    logic            commit;
    logic            issue_wr;

    // r0 is hardwired zero and never tracked.
    assign nz_all   = {nz, 1'b0};
    assign full_all = {full, 1'b0};
    assign busy_vec = nz_all;

    assign stall = iss_valid &&
                   ((iss_use_rs && (iss_rs != REG_ZERO) && nz_all[iss_rs]) ||
                    (iss_use_rt && (iss_rt != REG_ZERO) && nz_all[iss_rt]) ||
                    (iss_wr     && (iss_rd != REG_ZERO) && full_all[iss_rd]));

    assign issue_wr   = iss_valid && !stall && iss_wr && (iss_rd != REG_ZERO);
    assign link_ready = !buf_full;

    always_comb begin
        sel     = '0;
        capture = 1'b0;
        drain   = 1'b0;
        if (wb_valid) begin
            sel.we   = 1'b1;
            sel.addr = wb_rd;
            sel.data = wb_data;
            capture  = link_valid && !buf_full;
        end else if (buf_full) begin
            sel.we   = 1'b1;
            sel.addr = REG_LINK;
            sel.data = buf_data;
            drain    = 1'b1;
        end else if (link_valid) begin
            sel.we   = 1'b1;
            sel.addr = REG_LINK;
            sel.data = link_data;
        end
    end

    assign commit = sel.we && (sel.addr != REG_ZERO);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_vec[i] = issue_wr && (iss_rd == reg_idx_t'(i));
            dec_vec[i] = commit && (sel.addr == reg_idx_t'(i));
        end
    end

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        rf_pend_cnt #(.CW(CW)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc_vec[g]),
            .dec     (dec_vec[g]),
            .nonzero (nz[g]),
            .full    (full[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (capture) begin
            buf_full <= 1'b1;
            buf_data <= link_data;
        end else if (drain) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= commit;
            if (commit) begin
                rf_wa <= sel.addr;
                rf_wd <= sel.data;
            end
        end
    end

endmodule
